// File: rtl/bus_arbiter.sv
// N-channel registered bus arbiter: fixed-priority or round-robin selection,
// grant locking, and saturating conflict counting.
module bus_arbiter #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      CHANNELS   = 4,
  parameter int unsigned      MODE       = 0,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req_en,
  input  logic [CHANNELS*WIDTH-1:0] req_data,
  input  logic [CHANNELS-1:0]       lock,
  input  logic                      clear_count,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       grant,
  output logic                      conflict,
  output logic [15:0]               conflict_count
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic [IDX_W-1:0]    sel_idx_c;
  logic [IDX_W:0]      rr_sum_c;
  logic                found_c;
  logic                hold_c;
  logic                any_req_c;
  logic                multi_req_c;
  logic [CHANNELS-1:0] grant_d;
  logic [WIDTH-1:0]    out_d;
  logic [CNT_W-1:0]    count_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slice
    assign chan_data[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Next grant, data, pointer and counter
  always_comb begin
    hold_c      = |(grant & req_en & lock);
    any_req_c   = |req_en;
    multi_req_c = (req_en & (req_en - CHANNELS'(1))) != '0;
    sel_idx_c   = '0;
    rr_sum_c    = '0;
    found_c     = 1'b0;
    ptr_d       = ptr_q;
    if (hold_c) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (grant[i]) sel_idx_c = IDX_W'(i);
      end
    end else if (MODE == 0) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req_en[i]) sel_idx_c = IDX_W'(i);
      end
    end else begin
      // Search upward from the pointer, wrapping past the top channel
      for (int k = 0; k < CHANNELS; k++) begin
        rr_sum_c = {1'b0, ptr_q} + (IDX_W+1)'(k);
        if (rr_sum_c >= (IDX_W+1)'(CHANNELS)) rr_sum_c = rr_sum_c - (IDX_W+1)'(CHANNELS);
        if (!found_c && req_en[IDX_W'(rr_sum_c)]) begin
          found_c   = 1'b1;
          sel_idx_c = IDX_W'(rr_sum_c);
        end
      end
    end
    if (any_req_c && !hold_c) begin
      ptr_d = (sel_idx_c == IDX_W'(CHANNELS - 1)) ? '0 : sel_idx_c + IDX_W'(1);
    end
    grant_d = any_req_c ? (CHANNELS'(1) << sel_idx_c) : '0;
    out_d   = any_req_c ? chan_data[sel_idx_c] : IDLE_VALUE;
    if (clear_count) begin
      count_d = '0;
    end else if (multi_req_c && (conflict_count != CNT_MAX)) begin
      count_d = conflict_count + CNT_W'(1);
    end else begin
      count_d = conflict_count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out            <= IDLE_VALUE;
      out_valid      <= 1'b0;
      grant          <= '0;
      conflict       <= 1'b0;
      conflict_count <= '0;
      ptr_q          <= '0;
    end else begin
      out            <= out_d;
      out_valid      <= any_req_c;
      grant          <= grant_d;
      conflict       <= multi_req_c;
      conflict_count <= count_d;
      ptr_q          <= ptr_d;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised successor to the single shared 16-bit datapath bus.
- Replaces the fixed four-source OR/mux bus with an N-channel, W-bit registered arbiter.
- Supports fixed-priority or round-robin selection, multi-cycle grant locking, and conflict detection/counting.
- Sits between all bus drivers (ALU, memory, registers, controller, future I/O) and all bus consumers; `out` is the single shared bus value.

Parameters:
- WIDTH, 16, data width of each channel and of `out`.
- CHANNELS, 4, number of requesting sources (2..16).
- MODE, 0, 0 = fixed priority (channel 0 highest); 1 = round-robin.
- IDLE_VALUE, 0, value driven on `out` when no channel is granted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_en  input  CHANNELS  per-channel request (the source's out_en).
- req_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- lock  input  CHANNELS  per-channel hold request; keeps the current grant across cycles.
- clear_count  input  1  synchronous clear of conflict_count.
- out  output  WIDTH  registered bus value.
- out_valid  output  1  high when `out` carries granted data.
- grant  output  CHANNELS  registered one-hot grant, aligned with `out`.
- conflict  output  1  registered pulse: two or more req_en bits were high in the previous cycle.
- conflict_count  output  16  saturating count of conflict cycles.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-transfer):
  - out=IDLE_VALUE, out_valid=0, grant=0, conflict=0, conflict_count=0.
  - Round-robin pointer = 0; lock state cleared.
- Latency: one cycle. Requests sampled at edge N appear on out/grant/out_valid after edge N.
- Grant selection, evaluated each edge, in priority order:
  1. Lock hold: if the previous grant is channel g, and req_en[g]=1, and lock[g]=1, then channel g is granted again regardless of other requests.
  2. No requests (req_en=0): grant=0, out=IDLE_VALUE, out_valid=0.
  3. MODE=0: lowest-index requesting channel wins.
  4. MODE=1: first requesting channel at or after the pointer, searching upward with wrap from CHANNELS-1 to 0.
- Round-robin pointer update:
  - After any non-locked grant to channel g, pointer = (g+1) mod CHANNELS.
  - Pointer is unchanged on idle and on locked-hold cycles.
- Lock release:
  - Grantee deasserts lock or req_en: the next edge arbitrates normally.
  - lock on a non-granted channel is ignored.
  - If the grantee drops req_en while lock=1, lock is released (no stale grant).
- Data: out = req_data slice of the granted channel, width exactly WIDTH; no OR-merging of multiple drivers.
- Conflict detection:
  - conflict = 1 for one cycle after any edge at which popcount(req_en) ≥ 2, whether or not a lock was in effect.
- conflict_count:
  - +1 per conflict cycle; saturates at 0xFFFF, no wrap.
  - clear_count=1 forces 0 on that edge; clear wins over a simultaneous increment.
- Invariants:
  - grant is always one-hot or zero.
  - out_valid == |grant.
  - out == IDLE_VALUE whenever out_valid=0.

Test Plan:
- Reset/idle: rst=0 mid-transfer, then release with req_en=0 -> out=0x0000, out_valid=0, grant=0000, conflict_count=0, with out cleared asynchronously before the next edge.
- Fixed priority (MODE=0): req_en=0110, ch1=0x1234, ch2=0xBEEF -> after one edge out=0x1234, grant=0010, conflict=1, conflict_count=1.
- Round-robin (MODE=1): req_en=1111 held for 5 cycles, ch i data = 0xA000+i -> grant sequence 0001,0010,0100,1000,0001; out 0xA000,0xA001,0xA002,0xA003,0xA000.
- Lock (MODE=1): ch2 granted with lock[2]=1 and req_en=1111 for 3 cycles -> grant stays 0100 for those 3 cycles; lock[2] drops -> next grant=1000.
- Grantee drop under lock: ch1 granted, lock[1]=1, then req_en[1]=0 with req_en=0100 -> next grant=0100, out=ch2 data.
- Counter: force conflict_count to 0xFFFE, apply 3 conflict cycles -> 0xFFFF held; clear_count=1 together with a conflict -> 0x0000.
